// File: rtl/invader_formation_if.sv
`default_nettype none
// ============================================================================
// Module      : invader_formation_if
// Description : Frame, kill and formation-state bundle between the game
//               logic (master) and the invader formation block (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface invader_formation_if;
    logic        frame;
    logic        game_start;
    logic [5:0]  invader_collision;
    logic [54:0] invaders;
    logic [9:0]  invaders_x;
    logic [9:0]  invaders_y;
    logic        moving_right;
    logic [5:0]  alive_count;
    logic        kill_pulse;
    logic [2:0]  kill_row;
    logic        wave_clear;
    logic        invaded;

    modport master (
        output frame, game_start, invader_collision,
        input  invaders, invaders_x, invaders_y, moving_right, alive_count,
               kill_pulse, kill_row, wave_clear, invaded
    );

    modport slave (
        input  frame, game_start, invader_collision,
        output invaders, invaders_x, invaders_y, moving_right, alive_count,
               kill_pulse, kill_row, wave_clear, invaded
    );
endinterface
`default_nettype wire

// File: rtl/invader_formation.sv
`default_nettype none
// ============================================================================
// Module      : invader_formation
// Description : Owns the 11x5 invader formation: alive mask, origin, march
//               direction and speed, kill handling, wave-clear and landing.
// Revision    : 1.0 - initial release
// ============================================================================
module invader_formation #(
    parameter int INVADERS_H  = 11,
    parameter int INVADERS_V  = 5,
    parameter int OFFSET_H    = 40,
    parameter int OFFSET_V    = 32,
    parameter int SPR_W       = 32,
    parameter int SPR_H       = 16,
    parameter int STEP_X      = 4,
    parameter int STEP_Y      = 16,
    parameter int LEFT_BOUND  = 16,
    parameter int RIGHT_BOUND = 624,
    parameter int START_X     = 96,
    parameter int START_Y     = 64,
    parameter int FLOOR_Y     = 400,
    parameter int PERIOD_MIN  = 1
) (
    input  wire logic           clk,
    input  wire logic           rst,
    invader_formation_if.slave  bus
);

    localparam int c_N = INVADERS_H * INVADERS_V;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_CLEAR  = 2'd2,
        S_LANDED = 2'd3
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [c_N-1:0]  r_mask, w_mask_nxt;
    logic [9:0]      r_x, w_x_nxt;
    logic [9:0]      r_y, w_y_nxt;
    logic            r_mr, w_mr_nxt;
    logic [5:0]      r_alive, w_alive_nxt;
    logic [5:0]      r_cnt, w_cnt_nxt;
    logic            r_pulse, w_pulse_nxt;
    logic [2:0]      r_row, w_row_nxt;

    // Column / row occupancy of the registered mask
    logic [INVADERS_H-1:0] w_col_or;
    logic [INVADERS_V-1:0] w_row_or;
    logic [3:0]            w_left, w_right;
    logic [2:0]            w_bottom;

    for (genvar c = 0; c < INVADERS_H; c++) begin : g_col
        logic [INVADERS_V-1:0] w_bits;
        for (genvar r = 0; r < INVADERS_V; r++) begin : g_bit
            assign w_bits[r] = r_mask[r*INVADERS_H + c];
        end
        assign w_col_or[c] = |w_bits;
    end

    for (genvar r = 0; r < INVADERS_V; r++) begin : g_row
        assign w_row_or[r] = |r_mask[r*INVADERS_H +: INVADERS_H];
    end

    // Leftmost / rightmost alive column and bottom alive row
    always_comb begin
        w_left   = '0;
        w_right  = '0;
        w_bottom = '0;
        for (int c = INVADERS_H - 1; c >= 0; c--)
            if (w_col_or[c]) w_left = 4'(c);
        for (int c = 0; c < INVADERS_H; c++)
            if (w_col_or[c]) w_right = 4'(c);
        for (int r = 0; r < INVADERS_V; r++)
            if (w_row_or[r]) w_bottom = 3'(r);
    end

    // Kill decode: code k addresses mask bit k-1
    logic [5:0]     w_kidx;
    logic [c_N-1:0] w_mask_sh;
    logic           w_kill;
    logic [2:0]     w_kill_row;

    assign w_kidx     = bus.invader_collision - 6'd1;
    assign w_mask_sh  = r_mask >> w_kidx;
    assign w_kill     = (bus.invader_collision != 6'd0) &&
                        (bus.invader_collision <= 6'(c_N)) && w_mask_sh[0];
    assign w_kill_row = 3'(w_kidx / 6'(INVADERS_H));

    // Step cadence: fewer invaders alive means fewer frames per step
    logic [6:0] w_period, w_cnt_inc;
    logic       w_step_due;

    assign w_period   = 7'(r_alive >> 1) + 7'(PERIOD_MIN);
    assign w_cnt_inc  = 7'(r_cnt) + 7'd1;
    assign w_step_due = bus.frame && (w_cnt_inc >= w_period);

    // Edge and floor tests, 11 bits wide so the sums cannot wrap
    logic [10:0] w_right_px, w_left_px, w_floor_px;
    logic [9:0]  w_y_down;
    logic        w_hit_right, w_hit_left, w_land;

    assign w_right_px  = {1'b0, r_x} + 11'(w_right) * 11'(OFFSET_H)
                         + 11'(SPR_W) + 11'(STEP_X);
    assign w_left_px   = {1'b0, r_x} + 11'(w_left) * 11'(OFFSET_H);
    assign w_hit_right = w_right_px > 11'(RIGHT_BOUND);
    assign w_hit_left  = w_left_px < 11'(LEFT_BOUND + STEP_X);
    assign w_y_down    = r_y + 10'(STEP_Y);
    assign w_floor_px  = {1'b0, w_y_down} + 11'(w_bottom) * 11'(OFFSET_V)
                         + 11'(SPR_H);
    assign w_land      = w_floor_px >= 11'(FLOOR_Y);

    // Next-state: kills, marching, descent, landing and wave reload
    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_mr_nxt    = r_mr;
        w_alive_nxt = r_alive;
        w_cnt_nxt   = r_cnt;
        w_pulse_nxt = 1'b0;
        w_row_nxt   = r_row;

        if (r_state == S_RUN) begin
            if (w_kill) begin
                w_mask_nxt  = r_mask & ~({{(c_N-1){1'b0}}, 1'b1} << w_kidx);
                w_alive_nxt = r_alive - 6'd1;
                w_pulse_nxt = 1'b1;
                w_row_nxt   = w_kill_row;
            end
            if (w_kill && r_alive == 6'd1) begin
                // Last invader gone: freeze, any step this cycle is dropped
                w_state_nxt = S_CLEAR;
            end else if (bus.frame) begin
                if (w_step_due) begin
                    w_cnt_nxt = '0;
                    if ((r_mr && w_hit_right) || (!r_mr && w_hit_left)) begin
                        w_y_nxt  = w_y_down;
                        w_mr_nxt = !r_mr;
                        if (w_land) w_state_nxt = S_LANDED;
                    end else if (r_mr) begin
                        w_x_nxt = r_x + 10'(STEP_X);
                    end else begin
                        w_x_nxt = r_x - 10'(STEP_X);
                    end
                end else begin
                    w_cnt_nxt = w_cnt_inc[5:0];
                end
            end
        end

        if (bus.game_start) begin
            w_state_nxt = S_RUN;
            w_mask_nxt  = '1;
            w_x_nxt     = 10'(START_X);
            w_y_nxt     = 10'(START_Y);
            w_mr_nxt    = 1'b1;
            w_alive_nxt = 6'(c_N);
            w_cnt_nxt   = '0;
            w_pulse_nxt = 1'b0;
            w_row_nxt   = '0;
        end
    end

    // Formation state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_mask  <= '1;
            r_x     <= 10'(START_X);
            r_y     <= 10'(START_Y);
            r_mr    <= 1'b1;
            r_alive <= 6'(c_N);
            r_cnt   <= '0;
            r_pulse <= 1'b0;
            r_row   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mask  <= w_mask_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_mr    <= w_mr_nxt;
            r_alive <= w_alive_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pulse <= w_pulse_nxt;
            r_row   <= w_row_nxt;
        end
    end

    assign bus.invaders     = r_mask;
    assign bus.invaders_x   = r_x;
    assign bus.invaders_y   = r_y;
    assign bus.moving_right = r_mr;
    assign bus.alive_count  = r_alive;
    assign bus.kill_pulse   = r_pulse;
    assign bus.kill_row     = r_row;
    assign bus.wave_clear   = (r_state == S_CLEAR);
    assign bus.invaded      = (r_state == S_LANDED);

endmodule
`default_nettype wire

// File: tb/tb_invader_formation.sv
`default_nettype none
// ============================================================================
// Module      : tb_invader_formation
// Description : Directed, self-checking bench for invader_formation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_invader_formation;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    invader_formation_if bus();

    invader_formation u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] code;
        logic [5:0] alive;
        logic       pulse;
        logic [2:0] row;
        int         bit_idx;
        logic       bit_val;
    } kvec_t;

    kvec_t kv [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic pulse_frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); bus.frame = 1'b1;
            @(posedge clk); #1;
        end
        @(negedge clk); bus.frame = 1'b0;
    endtask

    task automatic start_wave();
        @(negedge clk); bus.game_start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); bus.game_start = 1'b0;
    endtask

    task automatic kill(input int code);
        @(negedge clk); bus.invader_collision = 6'(code);
        @(posedge clk); #1;
        @(negedge clk); bus.invader_collision = 6'd0;
    endtask

    // Steps until landing; returns last y seen before landing and step count
    task automatic run_to_land(input int period, output int prev_y, output int steps);
        prev_y = -1;
        steps  = 0;
        while (!bus.invaded && steps < 800) begin
            if (!bus.invaded) prev_y = int'(bus.invaders_y);
            pulse_frames(period);
            steps++;
        end
    endtask

    initial begin
        int prev_y, steps;

        kv[0] = '{6'd1,  6'd54, 1'b1, 3'd0, 0,  1'b0};
        kv[1] = '{6'd55, 6'd53, 1'b1, 3'd4, 54, 1'b0};
        kv[2] = '{6'd1,  6'd53, 1'b0, 3'd4, 0,  1'b0};
        kv[3] = '{6'd60, 6'd53, 1'b0, 3'd4, 54, 1'b0};
        kv[4] = '{6'd0,  6'd53, 1'b0, 3'd4, 1,  1'b1};
        kv[5] = '{6'd12, 6'd52, 1'b1, 3'd1, 11, 1'b0};
        kv[6] = '{6'd34, 6'd51, 1'b1, 3'd3, 33, 1'b0};
        kv[7] = '{6'd63, 6'd51, 1'b0, 3'd3, 10, 1'b1};

        bus.frame = 1'b0;
        bus.game_start = 1'b0;
        bus.invader_collision = 6'd0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mask",  bus.invaders, 64'({55{1'b1}}));
        chk("rst_x",     bus.invaders_x, 96);
        chk("rst_y",     bus.invaders_y, 64);
        chk("rst_mr",    bus.moving_right, 1);
        chk("rst_alive", bus.alive_count, 55);
        chk("rst_pulse", bus.kill_pulse, 0);
        chk("rst_row",   bus.kill_row, 0);
        chk("rst_clear", bus.wave_clear, 0);
        chk("rst_inv",   bus.invaded, 0);
        @(negedge clk); rst = 1'b0;

        // IDLE ignores frames and kills
        pulse_frames(30);
        kill(3);
        chk("idle_x",     bus.invaders_x, 96);
        chk("idle_alive", bus.alive_count, 55);

        // March: 28 frames per step at full strength
        start_wave();
        pulse_frames(27);
        chk("march_27_x", bus.invaders_x, 96);
        pulse_frames(1);
        chk("march_1_x",  bus.invaders_x, 100);
        chk("march_1_y",  bus.invaders_y, 64);
        chk("march_1_mr", bus.moving_right, 1);
        chk("march_1_al", bus.alive_count, 55);
        chk("march_1_kp", bus.kill_pulse, 0);
        pulse_frames(23 * 28);
        chk("march_24_x", bus.invaders_x, 192);
        pulse_frames(28);
        chk("march_25_x",  bus.invaders_x, 192);
        chk("march_25_y",  bus.invaders_y, 80);
        chk("march_25_mr", bus.moving_right, 0);
        pulse_frames(28);
        chk("march_26_x", bus.invaders_x, 188);

        // Kill table
        start_wave();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); bus.invader_collision = kv[i].code;
            @(posedge clk); #1;
            chk("kill_alive", bus.alive_count, kv[i].alive);
            chk("kill_pulse", bus.kill_pulse, kv[i].pulse);
            chk("kill_row",   bus.kill_row, kv[i].row);
            chk("kill_bit",   bus.invaders[kv[i].bit_idx], kv[i].bit_val);
            @(negedge clk); bus.invader_collision = 6'd0;
            @(posedge clk); #1;
            chk("kill_pulse_end", bus.kill_pulse, 0);
        end

        // game_start beats a same-cycle kill
        @(negedge clk); bus.game_start = 1'b1; bus.invader_collision = 6'd5;
        @(posedge clk); #1;
        chk("prio_alive", bus.alive_count, 55);
        chk("prio_bit4",  bus.invaders[4], 1);
        chk("prio_bit0",  bus.invaders[0], 1);
        chk("prio_pulse", bus.kill_pulse, 0);
        @(negedge clk); bus.game_start = 1'b0; bus.invader_collision = 6'd0;

        // Columns 9 and 10 removed: 45 alive, period 23, reversal at x=272
        start_wave();
        for (int r = 0; r < 5; r++) begin
            kill(r * 11 + 10);
            kill(r * 11 + 11);
        end
        chk("c910_alive", bus.alive_count, 45);
        pulse_frames(22);
        chk("c910_22_x", bus.invaders_x, 96);
        pulse_frames(1);
        chk("c910_23_x", bus.invaders_x, 100);
        pulse_frames(43 * 23);
        chk("c910_x272",  bus.invaders_x, 272);
        chk("c910_mr1",   bus.moving_right, 1);
        pulse_frames(23);
        chk("c910_rev_x",  bus.invaders_x, 272);
        chk("c910_rev_y",  bus.invaders_y, 80);
        chk("c910_rev_mr", bus.moving_right, 0);

        // Wave clear
        start_wave();
        for (int k = 1; k <= 54; k++) kill(k);
        chk("clr_pre", bus.wave_clear, 0);
        @(negedge clk); bus.invader_collision = 6'd55;
        @(posedge clk); #1;
        chk("clr_flag",  bus.wave_clear, 1);
        chk("clr_alive", bus.alive_count, 0);
        chk("clr_mask",  bus.invaders, 0);
        @(negedge clk); bus.invader_collision = 6'd0;
        pulse_frames(60);
        chk("clr_x", bus.invaders_x, 96);
        chk("clr_y", bus.invaders_y, 64);
        start_wave();
        chk("clr_rs_mask", bus.invaders, 64'({55{1'b1}}));
        chk("clr_rs_flag", bus.wave_clear, 0);
        pulse_frames(28);
        chk("clr_rs_run", bus.invaders_x, 100);

        // Landing with full mask
        start_wave();
        run_to_land(28, prev_y, steps);
        chk("land_bound",  (steps < 800), 1);
        chk("land_prev_y", prev_y, 240);
        chk("land_y",      bus.invaders_y, 256);
        chk("land_flag",   bus.invaded, 1);
        begin
            logic [9:0] lx;
            lx = bus.invaders_x;
            pulse_frames(60);
            chk("land_frz_x", bus.invaders_x, lx);
            chk("land_frz_y", bus.invaders_y, 256);
        end

        // Landing with bottom row gone
        start_wave();
        for (int k = 45; k <= 55; k++) kill(k);
        chk("r4_alive", bus.alive_count, 44);
        run_to_land(23, prev_y, steps);
        chk("r4_bound",  (steps < 800), 1);
        chk("r4_prev_y", prev_y, 272);
        chk("r4_y",      bus.invaders_y, 288);
        chk("r4_flag",   bus.invaded, 1);

        // Asynchronous reset takes effect before the next clock edge
        @(negedge clk); #2 rst = 1'b1;
        #1;
        chk("arst_y",     bus.invaders_y, 64);
        chk("arst_inv",   bus.invaded, 0);
        chk("arst_alive", bus.alive_count, 55);
        chk("arst_mask",  bus.invaders, 64'({55{1'b1}}));
        @(negedge clk); rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
